alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised, registered, multi-cycle ALU for the execute stage of the pipelined processor. It replaces the bit-sliced combinational ALU with a WIDTH-bit unit. The ALUctl encoding is unchanged, and two new iterative operations are added: unsigned multiply and unsigned divide, with a HI result word. Single-cycle operations issue one per clock. Multiply and divide stall issue through `in_ready` until they complete.

## Interface
- `WIDTH`, default 32: operand and result width, ≥4.
- `CNT_W`, default $clog2(WIDTH+1): iteration counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-high.
- `in_valid`  in  1  operands and ALUctl are presented.
- `in_ready`  out  1  = (state==IDLE) & ~flush. Combinational.
- `ALUctl`  in  4  operation select.
- `a`, `b`  in  WIDTH  operands.
- `flush`  in  1  synchronous abort of any in-flight operation.
- `out_valid`  out  1  one-cycle pulse: result registers are updated.
- `result`  out  WIDTH  main result; LO for multiply and divide.
- `hi`  out  WIDTH  product high word or remainder; 0 for single-cycle operations.
- `zero`  out  1  result==0.
- `c_out`  out  1  carry out of ADD/SUB adder.
- `ovf`  out  1  signed overflow of ADD/SUB.
- `dz`  out  1  divide by zero.

## Operation
- An operation is accepted at a clock edge where in_valid & in_ready.
- ALUctl encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB: a + ~b + 1
  - 0111 SLT: signed; result = {0…, a<b}
  - 1100 XOR
  - 1101 NOR
  - 1000 MULU
  - 1010 DIVU
  - Any other code gives result=0 and all flags 0. It is treated as a single-cycle operation.
- ADD/SUB:
  - c_out is the carry out of bit WIDTH-1. For SUB, c_out=1 means no borrow.
  - ovf = operand signs equal (after the SUB inversion) and result sign differs.
  - For all other operations, c_out and ovf are 0.
- SLT must be correct under overflow: less = sum[WIDTH-1] ^ ovf of a−b. For SLT, c_out and ovf report 0.
- MULU: shift-add, one partial product per cycle. {hi,result} = a*b, full 2·WIDTH-bit unsigned product.
- DIVU: restoring division, one quotient bit per cycle. result = a/b, hi = a%b.
  - If b==0: result = all ones, hi = a, dz = 1. The divide still takes the full latency.
- zero is computed on `result` only.
- All outputs are registered. When out_valid=0 they hold their last values.
- FSM states:
  - IDLE:
    - Accept a single-cycle op → write outputs, out_valid=1, stay in IDLE.
    - Accept MULU → MUL, count=WIDTH.
    - Accept DIVU → DIV, count=WIDTH.
  - MUL / DIV: each edge performs one iteration and decrements count. On the edge where count==1: write the outputs, out_valid=1, go to IDLE.
  - flush=1 at any edge: go to IDLE, out_valid=0, nothing is accepted, the in-flight operation is discarded, and the output registers are not written.

## Timing
- Reset values: every output register is 0 (result, hi, zero, c_out, ovf, dz, out_valid). State is IDLE, count is 0.
  - in_ready therefore reads 1 during reset unless flush is asserted.
- Single-cycle latency: accept at edge E0 → out_valid high for the cycle following E0. Throughput is 1 per clock, and in_ready stays high.
- Multi-cycle latency: accept at E0 → iterations at E1…E_WIDTH → out_valid high for the cycle following E_WIDTH. That is a latency of WIDTH edges.
  - in_ready is low from after E0 through E_WIDTH.
  - in_ready is high again in the same cycle as out_valid, so a new op can be accepted there. Its result pulses later.
- in_valid while in_ready=0: ignored. The source must hold its request.
- Asynchronous rst mid-operation: immediate return to the reset values. The aborted op never produces out_valid.
- flush and in_valid in the same cycle: flush wins. in_ready=0, so no accept.
- No output backpressure: the consumer must take the result in the out_valid cycle.

## Test plan
- WIDTH=32, ADD a=0x7FFFFFFF, b=1 → result=0x80000000, ovf=1, c_out=0, zero=0, out_valid 1 cycle after accept. Then SUB 5−5 → result=0, zero=1, c_out=1.
- SLT with a=0x80000000, b=0x00000001 → result=1. SLT with a=0x7FFFFFFF, b=0x80000000 → result=0 (overflow case).
- MULU a=0xFFFFFFFF, b=2 → result=0xFFFFFFFE, hi=1, out_valid exactly 32 edges after accept, in_ready low for 32 cycles. A back-to-back ADD issued in the out_valid cycle produces its result 1 cycle later.
- DIVU 100/7 → result=14, hi=2, dz=0. DIVU 9/0 → result=0xFFFFFFFF, hi=9, dz=1, same 32-edge latency.
- flush asserted at iteration 10 of a MULU → no out_valid ever for it, outputs unchanged, in_ready=1 the cycle after flush deasserts. A following ADD 3+4 gives 7.
- rst asserted mid-DIVU, between clock edges → all outputs 0 immediately, no out_valid for that divide after rst releases. A subsequent XOR 0xF0F0F0F0^0xFFFFFFFF gives 0x0F0F0F0F.

Source files
------------

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU: single-cycle logic/arith ops plus iterative
// shift-add unsigned multiply and restoring unsigned divide with a HI word.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             c_out,
  output logic             ovf,
  output logic             dz
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1100;
  localparam logic [3:0] OP_NOR  = 4'b1101;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1010;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 dzp_q, dzp_d;
  logic [WIDTH-1:0]     result_q, result_d, hi_q, hi_d;
  logic                 zero_q, zero_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic                 dz_q, dz_d, out_valid_q, out_valid_d;

  logic                 sub_s, sc_ovf_s, sc_c_s, add_ovf_s;
  logic [WIDTH-1:0]     b_eff_s, sc_res_s;
  logic [WIDTH:0]       sum_s, mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0]   mul_acc_s, div_acc_s;

  assign in_ready = (state_q == S_IDLE) & ~flush;

  // SUB and SLT share the adder as a + ~b + 1; overflow judged on the effective operands.
  assign sub_s     = (ALUctl == OP_SUB) | (ALUctl == OP_SLT);
  assign b_eff_s   = sub_s ? ~b : b;
  assign sum_s     = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_s};
  assign add_ovf_s = (a[WIDTH-1] == b_eff_s[WIDTH-1]) & (sum_s[WIDTH-1] != a[WIDTH-1]);

  // Single-cycle result and flags.
  always_comb begin
    sc_res_s = {WIDTH{1'b0}};
    sc_c_s   = 1'b0;
    sc_ovf_s = 1'b0;
    case (ALUctl)
      OP_AND: sc_res_s = a & b;
      OP_OR:  sc_res_s = a | b;
      OP_XOR: sc_res_s = a ^ b;
      OP_NOR: sc_res_s = ~(a | b);
      OP_ADD, OP_SUB: begin
        sc_res_s = sum_s[WIDTH-1:0];
        sc_c_s   = sum_s[WIDTH];
        sc_ovf_s = add_ovf_s;
      end
      OP_SLT: sc_res_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ add_ovf_s};
      default: sc_res_s = {WIDTH{1'b0}};
    endcase
  end

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}.
  assign mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                       (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign mul_acc_s   = {mul_sum_s, acc_q[WIDTH-1:1]};
  assign div_shift_s = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff_s  = div_shift_s - {1'b0, opb_q};
  assign div_acc_s   = div_diff_s[WIDTH] ? {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                         : {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Next-state and output-register update.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    dzp_d       = dzp_q;
    result_d    = result_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    out_valid_d = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
      count_d = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            case (ALUctl)
              OP_MULU: begin
                state_d = S_MUL;
                count_d = CNT_W'(WIDTH);
                acc_d   = {{WIDTH{1'b0}}, b};
                opb_d   = a;
                dzp_d   = 1'b0;
              end
              OP_DIVU: begin
                state_d = S_DIV;
                count_d = CNT_W'(WIDTH);
                acc_d   = {{WIDTH{1'b0}}, a};
                opb_d   = b;
                dzp_d   = (b == {WIDTH{1'b0}});
              end
              default: begin
                result_d    = sc_res_s;
                hi_d        = {WIDTH{1'b0}};
                zero_d      = (sc_res_s == {WIDTH{1'b0}});
                c_out_d     = sc_c_s;
                ovf_d       = sc_ovf_s;
                dz_d        = 1'b0;
                out_valid_d = 1'b1;
              end
            endcase
          end else begin
            state_d = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          acc_d   = (state_q == S_MUL) ? mul_acc_s : div_acc_s;
          count_d = count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            state_d     = S_IDLE;
            result_d    = acc_d[WIDTH-1:0];
            hi_d        = acc_d[2*WIDTH-1:WIDTH];
            zero_d      = (acc_d[WIDTH-1:0] == {WIDTH{1'b0}});
            c_out_d     = 1'b0;
            ovf_d       = 1'b0;
            dz_d        = (state_q == S_DIV) & dzp_q;
            out_valid_d = 1'b1;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= {CNT_W{1'b0}};
      acc_q       <= {(2*WIDTH){1'b0}};
      opb_q       <= {WIDTH{1'b0}};
      dzp_q       <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      hi_q        <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      dzp_q       <= dzp_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: issued ops push reference results; a negedge
// monitor pops and compares every out_valid pulse, including its cycle.
module tb_alu_mc;
  localparam int W = 32;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_XOR = 4'b1100,
                         OP_NOR = 4'b1101, OP_MULU = 4'b1000, OP_DIVU = 4'b1010;

  logic clk = 1'b0, rst, in_valid, flush, in_ready;
  logic [3:0] ALUctl;
  logic [W-1:0] a, b, result, hi;
  logic out_valid, zero, c_out, ovf, dz;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ALUctl(ALUctl),
    .a(a), .b(b), .flush(flush), .out_valid(out_valid), .result(result), .hi(hi),
    .zero(zero), .c_out(c_out), .ovf(ovf), .dz(dz)
  );

  typedef struct {
    logic [31:0] res, hi;
    logic zero, c, ovf, dz, chkz;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the arithmetic definition of each op.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint unsigned s;
    longint sd;
    logic [31:0] ny;
    int sx, sy;
    e.res = 32'd0; e.hi = 32'd0; e.c = 1'b0; e.ovf = 1'b0; e.dz = 1'b0; e.chkz = 1'b1; e.cyc = 0;
    ny = ~y; sx = $signed(x); sy = $signed(y);
    case (op)
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_XOR: e.res = x ^ y;
      OP_NOR: e.res = ~(x | y);
      OP_ADD: begin
        s = 64'(x) + 64'(y); e.res = s[31:0]; e.c = s[32];
        sd = longint'(sx) + longint'(sy);
        e.ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      OP_SUB: begin
        s = 64'(x) + 64'(ny) + 64'd1; e.res = s[31:0]; e.c = s[32];
        sd = longint'(sx) - longint'(sy);
        e.ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      OP_SLT: e.res = (sx < sy) ? 32'd1 : 32'd0;
      OP_MULU: begin s = 64'(x) * 64'(y); e.res = s[31:0]; e.hi = s[63:32]; end
      OP_DIVU: begin
        if (y == 32'd0) begin e.res = 32'hFFFF_FFFF; e.hi = x; e.dz = 1'b1; end
        else begin e.res = x / y; e.hi = x % y; end
      end
      default: e.chkz = 1'b0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    exp_t e;
    ALUctl = op; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      chk("issue_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(op, x, y);
    e.cyc = cyc + 1 + (((op == OP_MULU) || (op == OP_DIVU)) ? W : 0);
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("hi", 64'(hi), 64'(e.hi));
        chk("c_out", 64'(c_out), 64'(e.c));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("dz", 64'(dz), 64'(e.dz));
        if (e.chkz) chk("zero", 64'(zero), 64'(e.zero));
        chk("latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    logic [3:0] ops[12];
    logic [31:0] sv_res, sv_hi, ra, rb;
    int n;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR, OP_NOR, OP_MULU, OP_DIVU,
            4'b0011, 4'b1111, OP_ADD};
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ALUctl = 4'd0; a = '0; b = '0;
    #1;
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_flags", 64'({zero, c_out, ovf, dz, out_valid}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;

    issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    issue(OP_SUB, 32'd5, 32'd5);
    issue(OP_SLT, 32'h8000_0000, 32'h1);
    issue(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
    issue(OP_MULU, 32'hFFFF_FFFF, 32'd2);
    n = 0;
    while (!in_ready && n < 100) begin n++; @(posedge clk); #1; end
    chk("mul_busy_cycles", 64'(n), 64'(W));
    issue(OP_ADD, 32'd10, 32'd20);
    issue(OP_DIVU, 32'd100, 32'd7);
    issue(OP_DIVU, 32'd9, 32'd0);
    drain();

    // Flush part-way through a multiply; a simultaneous request must be ignored.
    sv_res = result; sv_hi = hi;
    issue(OP_MULU, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; ALUctl = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    void'(sb.pop_back());
    #1 chk("post_flush_in_ready", 64'(in_ready), 64'd1);
    repeat (W + 4) begin @(posedge clk); #1; end
    chk("flush_result_held", 64'(result), 64'(sv_res));
    chk("flush_hi_held", 64'(hi), 64'(sv_hi));
    issue(OP_ADD, 32'd3, 32'd4);
    drain();

    // Asynchronous reset in the middle of a divide.
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (5) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("midop_rst_result", 64'(result), 64'd0);
    chk("midop_rst_hi", 64'(hi), 64'd0);
    chk("midop_rst_flags", 64'({zero, c_out, ovf, dz, out_valid}), 64'd0);
    sb.delete();
    @(posedge clk); #2 rst = 1'b0;
    repeat (W + 5) begin @(posedge clk); #1; end
    issue(OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
    drain();

    // Randomised mix, biased toward boundary operands.
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 20));
        default: ra = ra;
      endcase
      issue(ops[$urandom_range(0, 11)], ra, rb);
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
